// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller: FSM state
// encodings, per-hazard counter width and the packed bundle of stall/flush
// controls driven towards PC, IF/ID, ID/EX and EX/MEM.
package pipe_hazard_ctrl_pkg;

    localparam int REG_W     = 5;  // architectural register index width
    localparam int ST_W      = 2;  // FSM state width
    localparam int SEQ_CNT_W = 3;  // bubble / redirect window counters

    localparam logic [ST_W-1:0] ST_RUN      = 2'd0;
    localparam logic [ST_W-1:0] ST_LU_STALL = 2'd1;
    localparam logic [ST_W-1:0] ST_MDU_WAIT = 2'd2;
    localparam logic [ST_W-1:0] ST_REDIRECT = 2'd3;

    // Field order is MSB first, so a 6-bit literal reads left to right.
    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic if_id_flush;
        logic id_ex_stall;
        logic id_ex_flush;
        logic ex_mem_flush;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE     = ctrl_t'(6'b000000);
    localparam ctrl_t CTRL_LU       = ctrl_t'(6'b110010);  // hold PC/IF-ID, bubble ID/EX
    localparam ctrl_t CTRL_MDU      = ctrl_t'(6'b110101);  // freeze front end, bubble EX/MEM
    localparam ctrl_t CTRL_REDIRECT = ctrl_t'(6'b001010);  // squash the two younger stages
    localparam ctrl_t CTRL_RED_TAIL = ctrl_t'(6'b001000);  // squash late imem returns only
    localparam ctrl_t CTRL_RESET    = ctrl_t'(6'b001011);  // all bubbles, nothing held

endpackage

// File: rtl/pipe_lu_detect.sv
// Load-use hazard compare: the instruction in ID reads a register that the
// load currently in EX has not yet produced. x0 never carries a hazard.
module pipe_lu_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] id_rs1_i,
    input  logic [REG_W-1:0] id_rs2_i,
    input  logic             id_rs1_used_i,
    input  logic             id_rs2_used_i,
    input  logic             ex_mem_read_i,
    input  logic [REG_W-1:0] ex_rd_i,
    output logic             lu_hit_o
);

    logic rs1_match;
    logic rs2_match;

    assign rs1_match = id_rs1_used_i && (id_rs1_i == ex_rd_i);
    assign rs2_match = id_rs2_used_i && (id_rs2_i == ex_rd_i);
    assign lu_hit_o  = ex_mem_read_i && (ex_rd_i != '0) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush scheduler for the 5-stage core. Controls are
// combinational from the registered FSM state plus the current hazard
// inputs, so a hazard takes effect in the cycle it is seen. Also keeps a
// saturating count of cycles in which the PC was held.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned LU_BUBBLES     = 1,   // 1..7
    parameter int unsigned REDIRECT_EXTRA = 0,   // 0..7
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_redirect,
    input  logic             mdu_start,
    input  logic             mdu_done,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic [CNT_W-1:0] stall_cycles
);

    // The first load-use bubble is issued from RUN, so the window counter
    // only covers the remaining ones.
    localparam logic [SEQ_CNT_W-1:0] LU_RELOAD  = SEQ_CNT_W'(LU_BUBBLES - 1);
    localparam logic [SEQ_CNT_W-1:0] RED_RELOAD = SEQ_CNT_W'(REDIRECT_EXTRA);
    localparam logic [CNT_W-1:0]     CNT_MAX    = '1;
    localparam logic [CNT_W-1:0]     CNT_ONE    = CNT_W'(1);

    logic [ST_W-1:0]      state_q, state_d;
    logic [SEQ_CNT_W-1:0] bub_q, bub_d;
    logic [SEQ_CNT_W-1:0] red_q, red_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    ctrl_t                ctrl;
    logic                 lu_hit;

    pipe_lu_detect u_lu_detect (
        .id_rs1_i      (id_rs1),
        .id_rs2_i      (id_rs2),
        .id_rs1_used_i (id_rs1_used),
        .id_rs2_used_i (id_rs2_used),
        .ex_mem_read_i (ex_mem_read),
        .ex_rd_i       (ex_rd),
        .lu_hit_o      (lu_hit)
    );

    // Next-state and control decode; RUN arbitrates redirect > MDU > load-use.
    always_comb begin
        // NOTE: every variable gets a default before any branch, otherwise a
        // path that skips an assignment infers a latch.
        ctrl    = CTRL_NONE;
        state_d = state_q;
        bub_d   = bub_q;
        red_d   = red_q;

        if (!rst_n) begin
            // Reset acts on the controls immediately, not at the next edge.
            ctrl = CTRL_RESET;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (ex_redirect) begin
                        ctrl = CTRL_REDIRECT;
                        if (REDIRECT_EXTRA > 0) begin
                            state_d = ST_REDIRECT;
                            red_d   = RED_RELOAD;
                        end
                    end else if (mdu_start) begin
                        // A single-cycle op completes in place without stalling.
                        if (!mdu_done) begin
                            ctrl    = CTRL_MDU;
                            state_d = ST_MDU_WAIT;
                        end
                    end else if (lu_hit) begin
                        ctrl = CTRL_LU;
                        if (LU_BUBBLES > 1) begin
                            state_d = ST_LU_STALL;
                            bub_d   = LU_RELOAD;
                        end
                    end
                end

                ST_LU_STALL: begin
                    // The load has already moved on; the compare is stale here.
                    ctrl  = CTRL_LU;
                    bub_d = bub_q - 3'd1;
                    if (bub_q == 3'd1) begin
                        state_d = ST_RUN;
                    end
                end

                ST_MDU_WAIT: begin
                    // EX owns the MDU op; the done cycle still holds the front end.
                    ctrl = CTRL_MDU;
                    if (mdu_done) begin
                        state_d = ST_RUN;
                    end
                end

                ST_REDIRECT: begin
                    // ID holds a squashed bubble, so load-use cannot fire here.
                    if (ex_redirect) begin
                        ctrl  = CTRL_REDIRECT;
                        red_d = RED_RELOAD;
                    end else begin
                        ctrl  = CTRL_RED_TAIL;
                        red_d = red_q - 3'd1;
                        if (red_q == 3'd1) begin
                            state_d = ST_RUN;
                        end
                    end
                end

                default: state_d = ST_RUN;
            endcase
        end
    end

    // Saturating stall-cycle count, advanced on every cycle the PC is held.
    always_comb begin
        cnt_d = cnt_q;
        if (ctrl.pc_stall && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // State, window counters and perf counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q <= ST_RUN;
            bub_q   <= '0;
            red_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bub_q   <= bub_d;
            red_q   <= red_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc_stall     = ctrl.pc_stall;
    assign if_id_stall  = ctrl.if_id_stall;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_ex_stall  = ctrl.id_ex_stall;
    assign id_ex_flush  = ctrl.id_ex_flush;
    assign ex_mem_flush = ctrl.ex_mem_flush;
    assign stall_cycles = cnt_q;

    // EX cannot resolve a branch while it is occupied by a MUL/DIV.
    a_no_redirect_in_mdu : assert property (@(posedge clk) disable iff (!rst_n)
        !((state_q == ST_MDU_WAIT) && ex_redirect));

    // A pipeline register is never asked to hold and squash at once.
    a_if_id_excl : assert property (@(posedge clk) disable iff (!rst_n)
        !(if_id_stall && if_id_flush));
    a_id_ex_excl : assert property (@(posedge clk) disable iff (!rst_n)
        !(id_ex_stall && id_ex_flush));

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl. Two instances share one set of inputs:
// dut_a (LU_BUBBLES=1, REDIRECT_EXTRA=2, CNT_W=32) and dut_b (LU_BUBBLES=3,
// REDIRECT_EXTRA=0, CNT_W=4). Both are compared every cycle against a
// countdown-based reference model; directed tables and sequences add
// fixed expected values for the interesting cases.
module tb_pipe_hazard_ctrl;

    // Control bundle order: pc_stall, if_id_stall, if_id_flush,
    //                       id_ex_stall, id_ex_flush, ex_mem_flush
    localparam logic [5:0] C_IDLE = 6'b000000;
    localparam logic [5:0] C_LU   = 6'b110010;
    localparam logic [5:0] C_MDU  = 6'b110101;
    localparam logic [5:0] C_RED  = 6'b001010;
    localparam logic [5:0] C_TAIL = 6'b001000;
    localparam logic [5:0] C_RST  = 6'b001011;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic       id_rs1_used = 1'b0, id_rs2_used = 1'b0, ex_mem_read = 1'b0;
    logic       ex_redirect = 1'b0, mdu_start = 1'b0, mdu_done = 1'b0;

    logic        a_pc_stall, a_if_id_stall, a_if_id_flush, a_id_ex_stall, a_id_ex_flush, a_ex_mem_flush;
    logic        b_pc_stall, b_if_id_stall, b_if_id_flush, b_id_ex_stall, b_id_ex_flush, b_ex_mem_flush;
    logic [31:0] stall_a;
    logic [3:0]  stall_b;
    logic [5:0]  ctrl_a, ctrl_b, last_a, last_b;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.LU_BUBBLES(1), .REDIRECT_EXTRA(2), .CNT_W(32)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
        .mdu_start(mdu_start), .mdu_done(mdu_done),
        .pc_stall(a_pc_stall), .if_id_stall(a_if_id_stall), .if_id_flush(a_if_id_flush),
        .id_ex_stall(a_id_ex_stall), .id_ex_flush(a_id_ex_flush), .ex_mem_flush(a_ex_mem_flush),
        .stall_cycles(stall_a)
    );

    pipe_hazard_ctrl #(.LU_BUBBLES(3), .REDIRECT_EXTRA(0), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
        .mdu_start(mdu_start), .mdu_done(mdu_done),
        .pc_stall(b_pc_stall), .if_id_stall(b_if_id_stall), .if_id_flush(b_if_id_flush),
        .id_ex_stall(b_id_ex_stall), .id_ex_flush(b_id_ex_flush), .ex_mem_flush(b_ex_mem_flush),
        .stall_cycles(stall_b)
    );

    assign ctrl_a = {a_pc_stall, a_if_id_stall, a_if_id_flush, a_id_ex_stall, a_id_ex_flush, a_ex_mem_flush};
    assign ctrl_b = {b_pc_stall, b_if_id_stall, b_if_id_flush, b_id_ex_stall, b_id_ex_flush, b_ex_mem_flush};

    // Reference model: remaining-cycle countdowns instead of FSM states.
    typedef struct {
        bit     mdu_busy;   // waiting for mdu_done
        int     lu_left;    // load-use bubbles still owed after this one
        int     red_left;   // extra IF/ID squash cycles still owed
        longint cnt;        // stall cycles seen so far (saturated)
    } mdl_t;

    mdl_t m_a, m_b;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.mdu_busy = 1'b0;
        m.lu_left  = 0;
        m.red_left = 0;
        m.cnt      = 0;
        return m;
    endfunction

    function automatic void mdl_step(input mdl_t cur, input int lu_b, input int red_x,
                                     input int cnt_w, output logic [5:0] exp_ctrl,
                                     output mdl_t nxt);
        bit hit;
        hit = ex_mem_read && (ex_rd != 5'd0) &&
              ((id_rs1_used && (id_rs1 == ex_rd)) || (id_rs2_used && (id_rs2 == ex_rd)));
        nxt      = cur;
        exp_ctrl = C_IDLE;
        if (cur.mdu_busy) begin
            exp_ctrl = C_MDU;
            if (mdu_done) nxt.mdu_busy = 1'b0;
        end else if (cur.lu_left > 0) begin
            exp_ctrl    = C_LU;
            nxt.lu_left = cur.lu_left - 1;
        end else if (cur.red_left > 0) begin
            if (ex_redirect) begin
                exp_ctrl     = C_RED;
                nxt.red_left = red_x;
            end else begin
                exp_ctrl     = C_TAIL;
                nxt.red_left = cur.red_left - 1;
            end
        end else if (ex_redirect) begin
            exp_ctrl     = C_RED;
            nxt.red_left = red_x;
        end else if (mdu_start) begin
            if (!mdu_done) begin
                exp_ctrl     = C_MDU;
                nxt.mdu_busy = 1'b1;
            end
        end else if (hit) begin
            exp_ctrl    = C_LU;
            nxt.lu_left = lu_b - 1;
        end
        if (exp_ctrl[5] && (cur.cnt < ((longint'(1) << cnt_w) - 1)))
            nxt.cnt = cur.cnt + 1;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: compare at the falling edge, then advance the model on the rising edge.
    task automatic cycle();
        logic [5:0] ea, eb;
        mdl_t       na, nb;
        @(negedge clk);
        mdl_step(m_a, 1, 2, 32, ea, na);
        mdl_step(m_b, 3, 0, 4, eb, nb);
        check("model_ctrl_a", ctrl_a, ea);
        check("model_ctrl_b", ctrl_b, eb);
        check("model_cnt_a", stall_a, m_a.cnt);
        check("model_cnt_b", stall_b, m_b.cnt);
        last_a = ctrl_a;
        last_b = ctrl_b;
        @(posedge clk);
        m_a = na;
        m_b = nb;
        #1;
    endtask

    task automatic clear_inputs();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0; ex_mem_read = 1'b0;
        ex_redirect = 1'b0; mdu_start = 1'b0; mdu_done = 1'b0;
    endtask

    task automatic set_hit(input logic on);
        id_rs1 = 5'd4; id_rs1_used = 1'b1;
        id_rs2 = 5'd5; id_rs2_used = 1'b1;
        ex_rd = 5'd5;  ex_mem_read = on;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        #1;
        check("rst_ctrl_a", ctrl_a, C_RST);
        check("rst_ctrl_b", ctrl_b, C_RST);
        check("rst_cnt_a", stall_a, 0);
        check("rst_cnt_b", stall_b, 0);
        m_a = mdl_reset();
        m_b = mdl_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       mem_rd;
        logic [4:0] rd;
        logic       mstart;
        logic       mdone;
        logic [5:0] exp_a;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, C_IDLE};
        vecs[1] = '{5'd1,  5'd5,  1'b1, 1'b1, 1'b1, 5'd5,  1'b0, 1'b0, C_LU};
        vecs[2] = '{5'd0,  5'd0,  1'b1, 1'b1, 1'b1, 5'd0,  1'b0, 1'b0, C_IDLE};
        vecs[3] = '{5'd7,  5'd2,  1'b0, 1'b1, 1'b1, 5'd7,  1'b0, 1'b0, C_IDLE};
        vecs[4] = '{5'd7,  5'd2,  1'b1, 1'b0, 1'b1, 5'd7,  1'b0, 1'b0, C_LU};
        vecs[5] = '{5'd7,  5'd7,  1'b1, 1'b1, 1'b0, 5'd7,  1'b0, 1'b0, C_IDLE};
        vecs[6] = '{5'd3,  5'd0,  1'b1, 1'b0, 1'b1, 5'd3,  1'b1, 1'b1, C_IDLE};
        vecs[7] = '{5'd31, 5'd9,  1'b1, 1'b1, 1'b1, 5'd9,  1'b0, 1'b0, C_LU};
        vecs[8] = '{5'd31, 5'd30, 1'b1, 1'b1, 1'b1, 5'd29, 1'b0, 1'b0, C_IDLE};

        m_a = mdl_reset();
        m_b = mdl_reset();
        last_a = '0;
        last_b = '0;

        // Single-cycle decode from RUN on dut_a (LU_BUBBLES=1 keeps it in RUN).
        do_reset();
        for (int i = 0; i < 9; i++) begin
            id_rs1 = vecs[i].rs1;   id_rs2 = vecs[i].rs2;
            id_rs1_used = vecs[i].u1; id_rs2_used = vecs[i].u2;
            ex_mem_read = vecs[i].mem_rd; ex_rd = vecs[i].rd;
            mdu_start = vecs[i].mstart; mdu_done = vecs[i].mdone;
            ex_redirect = 1'b0;
            cycle();
            check($sformatf("vec%0d_ctrl_a", i), last_a, vecs[i].exp_a);
        end

        // Load-use with one bubble: exactly one stall cycle, counted once.
        do_reset();
        set_hit(1'b1);
        cycle();
        check("lu1_stall", last_a, C_LU);
        set_hit(1'b0);
        cycle();
        check("lu1_release", last_a, C_IDLE);
        check("lu1_count", stall_a, 1);

        // Three bubbles on dut_b; the hit vanishing after cycle 1 does not shorten it.
        do_reset();
        set_hit(1'b1);
        cycle();
        check("lu3_c0", last_b, C_LU);
        set_hit(1'b0);
        cycle();
        check("lu3_c1", last_b, C_LU);
        cycle();
        check("lu3_c2", last_b, C_LU);
        cycle();
        check("lu3_c3_run", last_b, C_IDLE);
        check("lu3_count", stall_b, 3);
        // Held hit: re-triggers from RUN, so stalls continue back to back.
        set_hit(1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("lu3_held", last_b, C_LU);
        end
        set_hit(1'b0);
        cycle();
        cycle();
        cycle();

        // Redirect: dut_a squashes IF/ID for 1+2 cycles, dut_b for one.
        do_reset();
        ex_redirect = 1'b1;
        cycle();
        check("red_c0_a", last_a, C_RED);
        check("red_c0_b", last_b, C_RED);
        ex_redirect = 1'b0;
        cycle();
        check("red_c1_a", last_a, C_TAIL);
        check("red_c1_b", last_b, C_IDLE);
        cycle();
        check("red_c2_a", last_a, C_TAIL);
        cycle();
        check("red_c3_a", last_a, C_IDLE);
        // Redirect wins over a simultaneous load-use; the window then masks it.
        set_hit(1'b1);
        ex_redirect = 1'b1;
        cycle();
        check("red_lu_a", last_a, C_RED);
        check("red_lu_b", last_b, C_RED);
        ex_redirect = 1'b0;
        cycle();
        check("red_lu_tail_a", last_a, C_TAIL);
        check("red_lu_run_b", last_b, C_LU);
        set_hit(1'b0);
        // A second redirect inside the window reloads it.
        ex_redirect = 1'b1;
        cycle();
        check("red_reload_a", last_a, C_RED);
        ex_redirect = 1'b0;
        cycle();
        check("red_reload_t1", last_a, C_TAIL);
        cycle();
        check("red_reload_t2", last_a, C_TAIL);
        cycle();
        check("red_reload_end", last_a, C_IDLE);

        // MDU with done four cycles after start: five stall cycles.
        do_reset();
        mdu_start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            mdu_done = (i == 4);
            cycle();
            mdu_start = 1'b0;
            check("mdu_wait", last_a, C_MDU);
        end
        mdu_done = 1'b0;
        cycle();
        check("mdu_after", last_a, C_IDLE);
        check("mdu_count", stall_a, 5);
        // Single-cycle op.
        mdu_start = 1'b1;
        mdu_done  = 1'b1;
        cycle();
        check("mdu_1cyc", last_a, C_IDLE);
        clear_inputs();
        cycle();
        check("mdu_1cyc_count", stall_a, 5);

        // Asynchronous reset in the second MDU_WAIT cycle.
        do_reset();
        mdu_start = 1'b1;
        cycle();
        mdu_start = 1'b0;
        cycle();
        #2 rst_n = 1'b0;
        #1;
        check("arst_ctrl_a", ctrl_a, C_RST);
        check("arst_ctrl_b", ctrl_b, C_RST);
        check("arst_cnt_a", stall_a, 0);
        m_a = mdl_reset();
        m_b = mdl_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        cycle();
        check("arst_run_a", last_a, C_IDLE);
        check("arst_run_cnt", stall_a, 0);

        // Counter saturation on the 4-bit instance over a 21-cycle wait.
        do_reset();
        mdu_start = 1'b1;
        cycle();
        mdu_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            mdu_done = (i == 19);
            cycle();
        end
        mdu_done = 1'b0;
        cycle();
        check("sat_b", stall_b, 15);
        check("sat_a", stall_a, 21);

        // Random traffic over small register indices to provoke hits.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            id_rs1      = 5'($urandom_range(0, 3));
            id_rs2      = 5'($urandom_range(0, 3));
            ex_rd       = 5'($urandom_range(0, 3));
            id_rs1_used = 1'($urandom_range(0, 1));
            id_rs2_used = 1'($urandom_range(0, 1));
            ex_mem_read = 1'($urandom_range(0, 1));
            mdu_start   = ($urandom_range(0, 9) == 0);
            mdu_done    = ($urandom_range(0, 3) == 0);
            ex_redirect = ($urandom_range(0, 9) == 0) && !m_a.mdu_busy && !m_b.mdu_busy;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
